// File: rtl/muxnway_pkg.sv
// Shared definitions for the registered N-way stream multiplexer: mode
// encodings and the select-width helper.
package muxnway_pkg;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mode_e;

  // A one-channel configuration still needs a 1-bit index port.
  function automatic int sel_width(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/muxnway_stream_if.sv
// Stream bundle for muxnway_stream: WAYS producer channels, one consumer and
// the selection controls. in_last exists only when MUXNWAY_LOCK_EN is defined.
interface muxnway_stream_if
  import muxnway_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int WAYS  = 8,
  parameter int SELW  = sel_width(WAYS)
) ();

  logic [WAYS*WIDTH-1:0] in_data;
  logic [WAYS-1:0]       in_valid;
  logic [WAYS-1:0]       in_ready;
`ifdef MUXNWAY_LOCK_EN
  logic [WAYS-1:0]       in_last;
`endif
  logic                  mode;
  logic [SELW-1:0]       sel;
  logic [WIDTH-1:0]      out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [SELW-1:0]       out_src;

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
`ifdef MUXNWAY_LOCK_EN
    input  in_last,
`endif
    input  mode,
    input  sel,
    output out_data,
    output out_valid,
    input  out_ready,
    output out_src
  );

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
`ifdef MUXNWAY_LOCK_EN
    output in_last,
`endif
    output mode,
    output sel,
    input  out_data,
    input  out_valid,
    output out_ready,
    input  out_src
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found
// searching upward from ptr, wrapping at WAYS.
module rr_arbiter
  import muxnway_pkg::*;
#(
  parameter int WAYS = 8,
  parameter int SELW = sel_width(WAYS)
) (
  input  logic [WAYS-1:0] req,
  input  logic [SELW-1:0] ptr,
  output logic [WAYS-1:0] grant,
  output logic [SELW-1:0] idx
);

  logic [SELW:0]   sum;
  logic [SELW-1:0] cand;
  logic            found;

  // NOTE: every output and temporary gets a default before the loop so no
  // path through the block leaves a value held, which would infer a latch.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < WAYS; k++) begin
      sum = {1'b0, ptr} + (SELW+1)'(k);
      if (sum >= (SELW+1)'(WAYS)) begin
        sum = sum - (SELW+1)'(WAYS);
      end
      cand = sum[SELW-1:0];
      if (!found && req[cand]) begin
        grant[cand] = 1'b1;
        idx         = cand;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/muxnway_stream.sv
// Registered N-way stream multiplexer with explicit-select or round-robin
// grant. Defining MUXNWAY_LOCK_EN adds in_last and holds the grant per packet.
module muxnway_stream
  import muxnway_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int WAYS  = 8,
  parameter int SELW  = sel_width(WAYS)
) (
  input  logic            clk,
  input  logic            rst_n,
  muxnway_stream_if.slave s
);

  logic [WIDTH-1:0] chan [WAYS];
  logic [WAYS-1:0]  arb_grant;
  logic [SELW-1:0]  arb_idx;
  logic [WAYS-1:0]  grant;
  logic [SELW-1:0]  gidx;
  logic [SELW-1:0]  next_ptr;
  logic [SELW-1:0]  rr_ptr;
  logic             sel_ok;
  logic             can_load;
  logic             xfer;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [SELW-1:0]  out_src_q;

`ifdef MUXNWAY_LOCK_EN
  logic             locked;
  logic             lock_rr;
  logic [SELW-1:0]  lock_ch;
`endif

  for (genvar i = 0; i < WAYS; i++) begin : g_chan
    assign chan[i] = s.in_data[i*WIDTH +: WIDTH];
  end

  rr_arbiter #(
    .WAYS (WAYS),
    .SELW (SELW)
  ) u_arb (
    .req   (s.in_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  assign sel_ok = {1'b0, s.sel} < (SELW+1)'(WAYS);

  always_comb begin
    grant = '0;
    gidx  = '0;
`ifdef MUXNWAY_LOCK_EN
    // A locked packet owns the output; a missing beat simply stalls it.
    if (locked) begin
      gidx          = lock_ch;
      grant[lock_ch] = s.in_valid[lock_ch];
    end else
`endif
    if (s.mode == MODE_RR) begin
      grant = arb_grant;
      gidx  = arb_idx;
    end else begin
      gidx = s.sel;
      if (sel_ok) begin
        grant[s.sel] = 1'b1;
      end
    end
  end

  // rst_n gates in_ready so no producer sees an accept while held in reset.
  assign can_load   = !out_valid_q || s.out_ready;
  assign s.in_ready = grant & {WAYS{can_load && rst_n}};
  assign xfer       = |(s.in_valid & s.in_ready);
  assign next_ptr   = (gidx == SELW'(WAYS-1)) ? '0 : gidx + SELW'(1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= chan[gidx];
      out_src_q   <= gidx;
    end else if (s.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef MUXNWAY_LOCK_EN
  // The pointer moves once per packet, at the beat that releases the lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr  <= '0;
      locked  <= 1'b0;
      lock_rr <= 1'b0;
      lock_ch <= '0;
    end else if (xfer) begin
      if (!s.in_last[gidx]) begin
        locked  <= 1'b1;
        lock_ch <= gidx;
        if (!locked) begin
          lock_rr <= (s.mode == MODE_RR);
        end
      end else begin
        locked <= 1'b0;
        if (locked ? lock_rr : (s.mode == MODE_RR)) begin
          rr_ptr <= next_ptr;
        end
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (xfer && (s.mode == MODE_RR)) begin
      rr_ptr <= next_ptr;
    end
  end
`endif

  assign s.out_valid = out_valid_q;
  assign s.out_data  = out_data_q;
  assign s.out_src   = out_src_q;

endmodule

// File: tb/tb_muxnway_stream.sv
// Directed bench for muxnway_stream: stimulus pushes expected beats into a
// scoreboard queue and a negedge monitor pops them on each output transfer.
module tb_muxnway_stream;
  import muxnway_pkg::*;

  localparam int WIDTH = 16;
  localparam int WAYS  = 8;
  localparam int SELW  = sel_width(WAYS);

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [SELW-1:0]  src;
  } beat_t;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] ch_data [WAYS];
  beat_t            sb [$];
  beat_t            mon_exp;
  int               total  = 0;
  int               passed = 0;

  muxnway_stream_if #(.WIDTH(WIDTH), .WAYS(WAYS)) bus ();

  for (genvar i = 0; i < WAYS; i++) begin : g_pack
    assign bus.in_data[i*WIDTH +: WIDTH] = ch_data[i];
  end

  muxnway_stream #(
    .WIDTH (WIDTH),
    .WAYS  (WAYS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_beat(input logic [WIDTH-1:0] d, input int src);
    sb.push_back('{data: d, src: SELW'(src)});
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL extra_beat: got data 0x%0h src %0d, expected no beat",
                 bus.out_data, bus.out_src);
      end else begin
        mon_exp = sb.pop_front();
        check("out_data", 32'(bus.out_data), 32'(mon_exp.data));
        check("out_src", 32'(bus.out_src), 32'(mon_exp.src));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid  = '0;
    bus.mode      = MODE_SEL;
    bus.sel       = 3'd3;
    bus.out_ready = 1'b0;
`ifdef MUXNWAY_LOCK_EN
    bus.in_last   = '1;
`endif
    for (int i = 0; i < WAYS; i++) ch_data[i] = '0;

    // Reset state; sel=3 in mode 0 would grant ch3 if in_ready were not gated.
    #2;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_out_src", 32'(bus.out_src), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: explicit select of ch3.
    ch_data[3]    = 16'h1234;
    bus.in_valid  = 8'h08;
    bus.out_ready = 1'b1;
    #1 check("t1_in_ready", 32'(bus.in_ready), 32'h08);
    expect_beat(16'h1234, 3);
    cycle();
    check("t1_out_valid", 32'(bus.out_valid), 32'd1);

    // 2: three-cycle stall, then accept with no bubble.
    bus.out_ready = 1'b0;
    ch_data[3]    = 16'h5678;
    repeat (3) begin
      #1;
      check("t2_stall_in_ready", 32'(bus.in_ready), 32'h00);
      check("t2_stall_out_data", 32'(bus.out_data), 32'h1234);
      cycle();
    end
    bus.out_ready = 1'b1;
    #1 check("t2_resume_in_ready", 32'(bus.in_ready), 32'h08);
    expect_beat(16'h5678, 3);
    cycle();
    bus.in_valid = '0;
    check("t2_no_bubble", 32'(bus.out_valid), 32'd1);
    cycle();
    check("t2_drained", 32'(bus.out_valid), 32'd0);

    // 3: round-robin over all channels, one beat per cycle.
    bus.mode = MODE_RR;
    for (int i = 0; i < WAYS; i++) ch_data[i] = 16'h3000 + 16'(i);
    bus.in_valid = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      expect_beat(16'h3000 + 16'(k % 8), k % 8);
      cycle();
      check("t3_out_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid = '0;
    cycle();

    // 4: sparse requesters ch2/ch6 with pointer wrap.
    for (int i = 0; i < WAYS; i++) ch_data[i] = 16'h4000 + 16'(i);
    bus.in_valid = 8'h44;
    expect_beat(16'h4002, 2);
    expect_beat(16'h4006, 6);
    expect_beat(16'h4002, 2);
    expect_beat(16'h4006, 6);
    repeat (4) cycle();
    bus.in_valid = '0;
    cycle();

    // 6: reset while a beat is stalled; first grant afterwards is ch0.
    bus.out_ready = 1'b0;
    ch_data[5]    = 16'h6555;
    bus.in_valid  = 8'h20;
    cycle();
    check("t6_loaded", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("t6_rst_in_ready", 32'(bus.in_ready), 32'h00);
    for (int i = 0; i < WAYS; i++) ch_data[i] = 16'h6000 + 16'(i);
    bus.in_valid  = 8'hFF;
    bus.out_ready = 1'b1;
    cycle();
    rst_n = 1'b1;
    #1 check("t6_first_grant", 32'(bus.in_ready), 32'h01);
    expect_beat(16'h6000, 0);
    cycle();
    bus.in_valid = '0;
    cycle();

`ifdef MUXNWAY_LOCK_EN
    // 5: rr_ptr is 1; ch1 sends a 4-beat packet while ch0/ch2 stay valid.
    ch_data[0]   = 16'h7000;
    ch_data[2]   = 16'h7002;
    bus.in_last  = 8'hFD;
    bus.in_valid = 8'h07;
    bus.mode     = MODE_RR;
    ch_data[1]   = 16'h7101;
    expect_beat(16'h7101, 1);
    cycle();
    ch_data[1] = 16'h7102;
    bus.mode   = MODE_SEL;
    bus.sel    = 3'd0;
    #1 check("t5_locked_in_ready", 32'(bus.in_ready), 32'h02);
    expect_beat(16'h7102, 1);
    cycle();
    ch_data[1] = 16'h7103;
    bus.sel    = 3'd2;
    expect_beat(16'h7103, 1);
    cycle();
    ch_data[1]  = 16'h7104;
    bus.in_last = 8'hFF;
    expect_beat(16'h7104, 1);
    cycle();
    bus.mode = MODE_RR;
    expect_beat(16'h7002, 2);
    cycle();
    bus.in_valid = '0;
    cycle();
`endif

    repeat (2) cycle();
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
